// File: rtl/kbd_event_scheduler.sv
// kbd_event_scheduler: FIFO-ordered keyboard event stream with valid/ready output.
// Define KBD_REPEAT_EN to add software auto-repeat of the last pressed non-modifier key.
module kbd_event_scheduler #(
  parameter int DEPTH  = 8,
  parameter int DELAY  = 50_000_000,
  parameter int PERIOD = 10_000_000,
  parameter int CW     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [8:0]               key_code,
  input  logic                     key_make,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [8:0]               ev_code,
  output logic                     ev_make,
  output logic                     ev_repeat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic          w_req, w_pop, w_full, w_acc;
  logic [10:0]   w_din, w_head;
  assign w_full   = r_cnt == (AW+1)'(DEPTH);
  assign ev_valid = r_cnt != '0;
  assign w_pop    = ev_valid && ev_ready;
  assign w_acc    = w_req && (!w_full || w_pop);
  assign w_head   = ev_valid ? r_mem[r_rp] : '0;
  assign {ev_repeat, ev_make, ev_code} = w_head;
  assign count    = r_cnt;
  assign overflow = r_ovf;
`ifdef KBD_REPEAT_EN
  typedef enum logic [1:0] {IDLE, DLY, RPT} state_t;
  localparam logic [CW-1:0] DLY_END = CW'(DELAY - 1);
  localparam logic [CW-1:0] RPT_END = CW'(PERIOD - 1);
  state_t        r_state;
  logic [8:0]    r_rep_code;
  logic [CW-1:0] r_tick;
  logic          r_rep_pend;
  logic          w_mod, w_act, w_nm_make, w_dup, w_brk;
  assign w_mod     = key_code inside {9'h012, 9'h059, 9'h014, 9'h114, 9'h011, 9'h111};
  assign w_act     = r_state != IDLE;
  assign w_nm_make = key_valid && key_make && !w_mod;
  // Typematic makes of the held key are swallowed; the engine owns its repeats.
  assign w_dup     = w_act && w_nm_make && key_code == r_rep_code;
  assign w_brk     = w_act && key_valid && !key_make && key_code == r_rep_code;
  assign w_req     = key_valid ? !w_dup : r_rep_pend;
  assign w_din     = key_valid ? {1'b0, key_make, key_code} : {2'b11, r_rep_code};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= IDLE;
      r_rep_code <= '0;
      r_tick     <= '0;
      r_rep_pend <= 1'b0;
    end else if (w_brk) begin
      r_state    <= IDLE;
      r_tick     <= '0;
      r_rep_pend <= 1'b0;
    end else if (w_nm_make && !w_dup) begin
      r_state    <= DLY;
      r_rep_code <= key_code;
      r_tick     <= '0;
      r_rep_pend <= 1'b0;
    end else if (w_act) begin
      if (r_tick == (r_state == DLY ? DLY_END : RPT_END)) begin
        r_state    <= RPT;
        r_tick     <= '0;
        r_rep_pend <= 1'b1;
      end else begin
        r_tick <= r_tick + CW'(1);
        if (!key_valid) r_rep_pend <= 1'b0;
      end
    end
`else
  logic w_unused;
  assign w_req    = key_valid;
  assign w_din    = {1'b0, key_make, key_code};
  assign w_unused = |{DELAY, PERIOD, CW};
`endif
  always_ff @(posedge clk)
    if (w_acc) r_mem[r_wp] <= w_din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_acc) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_acc) - (AW+1)'(w_pop);
      r_ovf <= (w_req && w_full && !w_pop) || (r_ovf && !clr_overflow);
    end
endmodule

// File: tb/tb_kbd_event_scheduler.sv
// tb_kbd_event_scheduler: directed checks of ordering, full handling and (when built) auto-repeat.
module tb_kbd_event_scheduler;
  logic       clk = 1'b0, rst = 1'b0, key_valid = 1'b0, key_make = 1'b0;
  logic       ev_ready = 1'b0, clr_overflow = 1'b0;
  logic [8:0] key_code = '0;
  logic       ev_valid, ev_make, ev_repeat, overflow;
  logic [8:0] ev_code;
  logic [3:0] count;
  logic [11:0] obs;
  int n_vec = 0, n_err = 0;

  kbd_event_scheduler #(.DEPTH(8), .DELAY(20), .PERIOD(5), .CW(8)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_make(key_make),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_make(ev_make),
    .ev_repeat(ev_repeat), .count(count), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;
  assign obs = {ev_valid, ev_repeat, ev_make, ev_code};

  task automatic drive(input logic v, input logic m, input logic [8:0] c);
    key_valid = v;
    key_make  = m;
    key_code  = c;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (obs !== 12'h000 || count !== 4'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset: head=%h count=%0d ovf=%b, want 000/0/0", obs, count, overflow);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    ev_ready = 1'b1;
    drive(1, 1, 9'h01C);
    @(negedge clk) drive(0, 0, 9'h000);
    n_vec++;
    if (obs !== {3'b101, 9'h01C} || count !== 4'd1) begin
      n_err++;
      $display("FAIL single_make: head=%h count=%0d, want %h/1", obs, count, {3'b101, 9'h01C});
    end
    @(negedge clk);
    n_vec++;
    if (obs !== 12'h000 || count !== 4'd0) begin
      n_err++;
      $display("FAIL single_pop: head=%h count=%0d, want 000/0", obs, count);
    end
    @(negedge clk) drive(1, 0, 9'h01C);
    @(negedge clk) drive(0, 0, 9'h000);
    n_vec++;
    if (obs !== {3'b100, 9'h01C}) begin
      n_err++;
      $display("FAIL single_break: head=%h, want %h", obs, {3'b100, 9'h01C});
    end
    @(negedge clk);
    n_vec++;
    if (count !== 4'd0 || ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_empty: count=%0d valid=%b, want 0/0", count, ev_valid);
    end
  endtask

  task automatic test_overflow;
    logic [8:0] want;
    ev_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      drive(1, 0, 9'(i));
      @(negedge clk);
    end
    drive(0, 0, 9'h000);
    n_vec++;
    if (count !== 4'd8 || overflow !== 1'b1 || obs !== {3'b100, 9'h001}) begin
      n_err++;
      $display("FAIL ovf_fill: count=%0d ovf=%b head=%h, want 8/1/%h", count, overflow, obs, {3'b100, 9'h001});
    end
    clr_overflow = 1'b1;
    @(negedge clk) clr_overflow = 1'b0;
    n_vec++;
    if (overflow !== 1'b0 || count !== 4'd8) begin
      n_err++;
      $display("FAIL ovf_clear: ovf=%b count=%0d, want 0/8", overflow, count);
    end
    drive(1, 0, 9'h0AA);
    ev_ready = 1'b1;
    @(negedge clk) drive(0, 0, 9'h000);
    ev_ready = 1'b0;
    n_vec++;
    if (count !== 4'd8 || overflow !== 1'b0 || ev_code !== 9'h002) begin
      n_err++;
      $display("FAIL full_push_pop: count=%0d ovf=%b code=%h, want 8/0/002", count, overflow, ev_code);
    end
    drive(1, 0, 9'h0BB);
    clr_overflow = 1'b1;
    @(negedge clk) drive(0, 0, 9'h000);
    clr_overflow = 1'b0;
    n_vec++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      n_err++;
      $display("FAIL ovf_set_wins: ovf=%b count=%0d, want 1/8", overflow, count);
    end
    clr_overflow = 1'b1;
    @(negedge clk) clr_overflow = 1'b0;
    n_vec++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear2: ovf=%b, want 0", overflow);
    end
    ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want = i < 7 ? 9'(i + 2) : 9'h0AA;
      n_vec++;
      if (obs !== {3'b100, want}) begin
        n_err++;
        $display("FAIL drain[%0d]: head=%h, want %h", i, obs, {3'b100, want});
      end
      @(negedge clk);
    end
    ev_ready = 1'b0;
    n_vec++;
    if (count !== 4'd0 || ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_empty: count=%0d valid=%b, want 0/0", count, ev_valid);
    end
  endtask

`ifndef KBD_REPEAT_EN
  task automatic test_duplicate;
    ev_ready = 1'b0;
    drive(1, 1, 9'h01C);
    @(negedge clk);
    @(negedge clk) drive(0, 0, 9'h000);
    n_vec++;
    if (count !== 4'd2) begin
      n_err++;
      $display("FAIL dup_count: count=%0d, want 2", count);
    end
    ev_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (obs !== {3'b101, 9'h01C}) begin
        n_err++;
        $display("FAIL dup_entry[%0d]: head=%h, want %h", i, obs, {3'b101, 9'h01C});
      end
      @(negedge clk);
    end
    ev_ready = 1'b0;
  endtask
`else
  task automatic test_repeat;
    logic [11:0] exp [60];
    foreach (exp[i]) exp[i] = 12'h000;
    exp[1]  = {3'b101, 9'h01C};
    exp[22] = {3'b111, 9'h01C};
    exp[27] = {3'b111, 9'h01C};
    exp[32] = {3'b111, 9'h01C};
    exp[37] = {3'b111, 9'h01C};
    exp[41] = {3'b100, 9'h01C};
    ev_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      drive(t == 0 || t == 10 || t == 40, t != 40, 9'h01C);
      n_vec++;
      if (obs !== exp[t]) begin
        n_err++;
        $display("FAIL repeat t=%0d: head=%h, want %h", t, obs, exp[t]);
      end
      @(negedge clk);
    end
    drive(0, 0, 9'h000);
  endtask

  task automatic test_modifier_switch;
    logic [11:0] exp [75];
    foreach (exp[i]) exp[i] = 12'h000;
    exp[1]  = {3'b101, 9'h012};
    exp[3]  = {3'b101, 9'h11C};
    exp[24] = {3'b111, 9'h11C};
    exp[29] = {3'b111, 9'h11C};
    exp[31] = {3'b101, 9'h023};
    exp[52] = {3'b100, 9'h012};
    exp[53] = {3'b111, 9'h023};
    exp[57] = {3'b111, 9'h023};
    exp[59] = {3'b100, 9'h023};
    exp[61] = {3'b100, 9'h11C};
    ev_ready = 1'b1;
    for (int t = 0; t < 75; t++) begin
      case (t)
        0:       drive(1, 1, 9'h012);
        2:       drive(1, 1, 9'h11C);
        30:      drive(1, 1, 9'h023);
        51:      drive(1, 0, 9'h012);
        58:      drive(1, 0, 9'h023);
        60:      drive(1, 0, 9'h11C);
        default: drive(0, 0, 9'h000);
      endcase
      n_vec++;
      if (obs !== exp[t]) begin
        n_err++;
        $display("FAIL modsw t=%0d: head=%h, want %h", t, obs, exp[t]);
      end
      @(negedge clk);
    end
    drive(0, 0, 9'h000);
  endtask

  task automatic test_reset_rpt;
    ev_ready = 1'b0;
    for (int t = 0; t < 28; t++) begin
      drive(t == 0, 1, 9'h01C);
      @(negedge clk);
    end
    drive(0, 0, 9'h000);
    n_vec++;
    if (count !== 4'd3 || ev_repeat !== 1'b0) begin
      n_err++;
      $display("FAIL rpt_queued: count=%0d rep=%b, want 3/0", count, ev_repeat);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (count !== 4'd0 || ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rpt_reset: count=%0d valid=%b, want 0/0", count, ev_valid);
    end
    @(negedge clk) rst = 1'b0;
    repeat (40) @(negedge clk);
    n_vec++;
    if (count !== 4'd0 || ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rpt_after_reset: count=%0d valid=%b, want 0/0", count, ev_valid);
    end
  endtask
`endif

  task automatic test_reset_mid;
    ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 9'(9'h031 + i));
      @(negedge clk);
    end
    drive(0, 0, 9'h000);
    n_vec++;
    if (count !== 4'd3) begin
      n_err++;
      $display("FAIL mid_queued: count=%0d, want 3", count);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (count !== 4'd0 || obs !== 12'h000 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: count=%0d head=%h ovf=%b, want 0/000/0", count, obs, overflow);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (count !== 4'd0 || ev_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_release: count=%0d valid=%b, want 0/0", count, ev_valid);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_overflow;
`ifndef KBD_REPEAT_EN
    test_duplicate;
`else
    test_repeat;
    test_modifier_switch;
    test_reset_rpt;
`endif
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/kbd_event_scheduler.md
# kbd_event_scheduler

Sequences key events from the PS/2 keyboard decoder into an ordered event stream for the IDE front end. The block buffers decoder events in a FIFO and, optionally, generates software auto-repeat for the most recently pressed non-modifier key. It presents events to a single downstream consumer over a valid/ready handshake. It sits between the keyboard decoder (`key_valid`/`last_change`) and the editor/command logic.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `DELAY`, 50_000_000: cycles from make to first repeat; ≥2.
- `PERIOD`, 10_000_000: cycles between repeats; ≥2.
- `CW`, 32: repeat counter width; must hold `max(DELAY,PERIOD)`.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `key_valid`  in  1  one-cycle decoder event strobe.
- `key_code`  in  9  `{extend, scan[7:0]}`; valid with `key_valid`.
- `key_make`  in  1  1 = press, 0 = release; valid with `key_valid`.
- `ev_valid`  out  1  head entry available.
- `ev_ready`  in  1  consumer accepts head this cycle.
- `ev_code`  out  9  head code.
- `ev_make`  out  1  head press/release.
- `ev_repeat`  out  1  head was generated by the repeat engine.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky: an event was dropped.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
- FIFO entry is `{repeat, make, code}`, 11 bits. Outputs are show-ahead from the head.
- `ev_valid = (count != 0)`. A pop occurs when `ev_valid && ev_ready`.
- Push sources are a decoder event (`key_valid`) and a pending repeat (`rep_pend`). At most one push occurs per cycle; the decoder event has priority.
- Full handling:
  - A push while `count == DEPTH` with no pop that cycle is dropped and sets `overflow`.
  - Push and pop in the same cycle while full: the push is accepted and `count` is unchanged.
  - Push and pop in the same cycle while empty: the push is accepted and the pop is ignored, because `ev_valid` was 0.
- `clr_overflow` clears `overflow`. If a set and a clear occur in the same cycle, the set wins.
- Modifier codes: 0x012, 0x059, 0x014, 0x114, 0x011, 0x111. Modifier events pass through to the FIFO and never affect the repeat FSM.
- Repeat FSM (repeat-enabled build only), registers `rep_code[8:0]` and `cnt[CW-1:0]`:
  - IDLE:
    - On a non-modifier make: `rep_code ← key_code`, `cnt ← 0`, go to DLY.
  - DLY:
    - `cnt` increments each cycle.
    - At `cnt == DELAY-1`: set `rep_pend`, `cnt ← 0`, go to RPT.
  - RPT:
    - `cnt` increments each cycle.
    - At `cnt == PERIOD-1`: set `rep_pend`, `cnt ← 0`.
  - DLY or RPT:
    - Break of `rep_code`: go to IDLE and clear `rep_pend`.
    - Non-modifier make of a different code: restart DLY with the new code and clear `rep_pend`.
    - Make of `rep_code` (keyboard typematic): not pushed and does not restart timing.
    - Break of any other code: pushed; FSM unaffected.
- `rep_pend` pushes `{1, 1, rep_code}` on the first cycle without `key_valid`, then clears.
  - A tick arriving while `rep_pend` is already set is absorbed; only one pending repeat is held.
  - A dropped repeat push sets `overflow` like any other dropped push.

## Timing
- Reset values:
  - All outputs 0.
  - FIFO empty, pointers 0.
  - FSM IDLE, `cnt` 0, `rep_pend` 0, `rep_code` 0.
- Latency: `key_valid` at cycle N gives `ev_valid` = 1 at N+1 (FIFO previously empty). The head is stable until popped.
- First repeat entry is pushed DELAY+1 cycles after the make's `key_valid` (DELAY cycles of counting plus one cycle for `rep_pend`), unless deferred.
- Subsequent repeat entries are spaced exactly PERIOD cycles apart, plus deferrals.
- Reset mid-operation: everything returns to reset values immediately. Queued events are lost. `overflow` clears.

## Configuration
- `KBD_REPEAT_EN` defined: repeat FSM, counter and typematic filtering are present, as described above.
- `KBD_REPEAT_EN` undefined:
  - FSM and counter are absent.
  - Every decoder event, including duplicate makes, is pushed.
  - `ev_repeat` is always 0.
  - `DELAY`, `PERIOD` and `CW` are ignored.

## Test plan
- Single event: `ev_ready` = 1; make 0x01C then break 0x01C, 3 cycles apart. Expect events {0,1,0x01C} then {0,0,0x01C}; `ev_valid` rises one cycle after each `key_valid`; `count` returns to 0.
- Overflow: `DEPTH` = 8, `ev_ready` = 0; push 9 breaks with codes 0x001–0x009. Expect `count` = 8, `overflow` = 1, head 0x001, 0x009 absent. Pulse `clr_overflow`: expect `overflow` = 0. Full push plus simultaneous pop: expect `count` stays 8.
- Repeat (`KBD_REPEAT_EN`, `DELAY` = 20, `PERIOD` = 5): make 0x01C at cycle 0, break at cycle 40.
  - Expect repeat entries {1,1,0x01C} pushed at cycles 21, 26, 31, 36, then the break entry.
  - Duplicate makes of 0x01C at cycle 10 are not queued.
- Modifier and switch: make 0x012 then make 0x11C.
  - Expect no repeats for 0x012.
  - Expect repeats for 0x11C only; make 0x023 mid-RPT restarts DLY with 0x023.
- Collision: `rep_pend` set in the same cycle as break 0x012. Expect the break entry first and the repeat entry the next cycle.
- Reset mid-RPT with 3 queued entries: expect `count` = 0, `ev_valid` = 0, and no repeat entries after reset is released.
